// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

   localparam logic [31:0] IFQ_RESET_PC = 32'h0040_0000;
   localparam logic [31:0] IFQ_NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] icode;
   } ifq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bus: instruction memory request/response plus dispatch/redirect.
// master = the fetch queue, slave = memory and dispatch.
interface instr_fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] ifq_icode;
   logic [31:0] ifq_pc;
   logic        ifq_empty;
   logic        dispatch_rd;
   logic [31:0] jump_branch_add;
   logic        jump_branch_valid;

   modport master (
      output imem_req, imem_addr, ifq_icode, ifq_pc, ifq_empty,
      input  imem_rvalid, imem_rdata, dispatch_rd, jump_branch_add, jump_branch_valid
   );

   modport slave (
      input  imem_req, imem_addr, ifq_icode, ifq_pc, ifq_empty,
      output imem_rvalid, imem_rdata, dispatch_rd, jump_branch_add, jump_branch_valid
   );
endinterface

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of {pc, icode} entries with flush; head is read straight
// from storage so the oldest entry is visible without an extra cycle.
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  ifq_entry_t             din,
   output ifq_entry_t             head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);

   ifq_entry_t      mem_q [DEPTH];
   ifq_entry_t      mem_d [DEPTH];
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [AW:0]     count_q, count_d;
   logic            do_pop;

   // Next pointers/storage; flush wins over push and pop.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      do_pop  = pop && (count_q != '0);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[tail_q] = din;
            tail_d        = tail_q + AW'(1);
         end
         if (do_pop) begin
            head_d = head_q + AW'(1);
         end
         count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
      end
   end

   // Storage and pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head  = mem_q[head_q];
   assign count = count_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch address generation, outstanding/drop tracking and the instruction queue.
// Each live request reserves a queue slot at issue time, so responses can
// always be pushed without backpressure on memory.
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
   input logic                 clk,
   input logic                 rst,
   instr_fetch_queue_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUT + 1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [OW-1:0] out_q, out_d;
   logic [OW-1:0] drop_q, drop_d;

   logic [CW-1:0] count;
   logic          empty;
   ifq_entry_t    head;
   ifq_entry_t    push_entry;
   logic          issue, drop_rsp, push, pop, jump, rvalid;
   logic [31:0]   live_total, target;

   assign jump   = bus.jump_branch_valid;
   assign rvalid = bus.imem_rvalid;
   assign target = {bus.jump_branch_add[31:2], 2'b00};

   // Issue decision, response routing and next counter/pc values.
   always_comb begin
      live_total = 32'(count) + 32'(out_q) - 32'(drop_q);
      issue      = !rst && !jump && (out_q < OW'(MAX_OUT)) && (live_total < 32'(DEPTH));
      drop_rsp   = rvalid && (drop_q != '0);
      push       = rvalid && !drop_rsp && !jump;
      pop        = bus.dispatch_rd && !jump;
      push_entry = '{pc: resp_pc_q, icode: bus.imem_rdata};

      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      out_d      = out_q + OW'(issue) - OW'(rvalid);
      drop_d     = drop_q;
      if (jump) begin
         // Everything still in flight belongs to the old stream.
         fetch_pc_d = target;
         resp_pc_d  = target;
         drop_d     = out_q - OW'(rvalid);
      end else begin
         if (issue)    fetch_pc_d = fetch_pc_q + 32'd4;
         if (push)     resp_pc_d  = resp_pc_q + 32'd4;
         if (drop_rsp) drop_d     = drop_q - OW'(1);
      end
   end

   // Fetch/response pcs and request accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end

   ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (jump),
      .din   (push_entry),
      .head  (head),
      .count (count),
      .empty (empty)
   );

   assign bus.imem_req  = issue;
   assign bus.imem_addr = fetch_pc_q;
   assign bus.ifq_empty = empty;
   assign bus.ifq_pc    = empty ? 32'h0 : head.pc;
   assign bus.ifq_icode = empty ? IFQ_NOP : head.icode;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a queue-based reference model
// and an in-order instruction memory with variable latency.
module tb_instr_fetch_queue;
   import ifq_pkg::*;

   localparam int          DEPTH   = 8;
   localparam int          MAX_OUT = 2;
   localparam logic [31:0] RST_PC  = 32'h0040_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_queue_if bus();

   instr_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RST_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { logic [31:0] pc; logic [31:0] icode; } m_ent_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   // Reference model state
   m_ent_t      m_q[$];
   int          m_out, m_drop;
   logic [31:0] m_fetch, m_resp;

   // Memory model state
   mreq_t mem_q[$];
   int    last_due, lat_min, lat_max;

   int cyc, n_req, n_chk, n_fail;

   function automatic logic [31:0] memfun(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_out   = 0;
      m_drop  = 0;
      m_fetch = RST_PC;
      m_resp  = RST_PC;
   endtask

   // One clock cycle: drive inputs, check outputs, advance the edge and the models.
   task automatic do_cycle(input logic r, input logic j, input logic [31:0] t, input logic rd);
      logic        rv, exp_req, got_req;
      logic [31:0] rdat, req_addr;
      int          lat, due;
      rst                   = r;
      bus.jump_branch_valid = j;
      bus.jump_branch_add   = t;
      bus.dispatch_rd       = rd;
      if (r) begin
         mem_q.delete();
         last_due = 0;
      end
      rv   = 1'b0;
      rdat = $urandom;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
         rv   = 1'b1;
         rdat = memfun(mem_q[0].addr);
         void'(mem_q.pop_front());
      end
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rdat;
      #1;
      exp_req = !r && !j && (m_out < MAX_OUT) && ((m_q.size() + m_out - m_drop) < DEPTH);
      chk("req", bus.imem_req, exp_req);
      chk("addr", bus.imem_addr, m_fetch);
      chk("empty", bus.ifq_empty, m_q.size() == 0);
      chk("pc", bus.ifq_pc, (m_q.size() == 0) ? 32'h0 : m_q[0].pc);
      chk("icode", bus.ifq_icode, (m_q.size() == 0) ? IFQ_NOP : m_q[0].icode);
      if (bus.ifq_empty === 1'b0) chk("icode_of_pc", bus.ifq_icode, memfun(bus.ifq_pc));
      got_req  = bus.imem_req;
      req_addr = bus.imem_addr;
      @(posedge clk);
      if (got_req === 1'b1) begin
         n_req++;
         lat = $urandom_range(lat_max, lat_min);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_q.push_back('{addr: req_addr, due: due});
      end
      cyc++;
      if (r) begin
         m_reset();
      end else if (j) begin
         m_q.delete();
         m_fetch = {t[31:2], 2'b00};
         m_resp  = {t[31:2], 2'b00};
         m_out   = m_out - int'(rv);
         m_drop  = m_out;
      end else begin
         if (rd && m_q.size() > 0) void'(m_q.pop_front());
         if (rv) begin
            if (m_drop > 0) m_drop--;
            else begin
               m_q.push_back('{pc: m_resp, icode: rdat});
               m_resp += 32'd4;
            end
            m_out--;
         end
         if (exp_req) begin
            m_fetch += 32'd4;
            m_out++;
         end
      end
      #1;
   endtask

   task automatic rand_cycle(input int p_rd, input int p_jmp, input int p_rst_pm);
      logic        r, j, rd;
      logic [31:0] t;
      r  = ($urandom_range(999) < p_rst_pm);
      j  = ($urandom_range(99) < p_jmp);
      rd = ($urandom_range(99) < p_rd);
      t  = RST_PC + ($urandom_range(255) << 2) + $urandom_range(3);
      do_cycle(r, j, t, rd);
   endtask

   task automatic wait_head(input string tag, input logic [31:0] exp_pc);
      int k;
      k = 0;
      while (bus.ifq_empty !== 1'b0 && k < 30) begin
         do_cycle(1'b0, 1'b0, 32'h0, 1'b0);
         k++;
      end
      chk({tag, "_timeout"}, 32'(k < 30), 32'd1);
      chk(tag, bus.ifq_pc, exp_pc);
      chk({tag, "_icode"}, bus.ifq_icode, memfun(exp_pc));
   endtask

   initial begin
      int k;
      n_chk = 0; n_fail = 0; cyc = 0; n_req = 0; last_due = 0;
      lat_min = 1; lat_max = 1;
      m_reset();
      rst = 1'b1;
      bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
      bus.dispatch_rd = 1'b0; bus.jump_branch_valid = 1'b0; bus.jump_branch_add = '0;
      repeat (2) @(posedge clk);
      #1;
      do_cycle(1'b1, 1'b0, 32'h0, 1'b0);

      // Fill with no dispatch: exactly DEPTH requests
      n_req = 0;
      repeat (20) do_cycle(1'b0, 1'b0, 32'h0, 1'b0);
      chk("t1_nreq", n_req, 32'd8);
      chk("t1_head", bus.ifq_pc, RST_PC);

      // Continuous dispatch, 1-cycle memory
      repeat (40) do_cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // Redirect with requests in flight on a 3-cycle memory
      lat_min = 3; lat_max = 3;
      repeat (12) do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 1'b1, 32'h0040_0100, 1'b1);
      chk("t3_empty", bus.ifq_empty, 1'b1);
      wait_head("t3_head", 32'h0040_0100);

      // Redirect in a cycle that also carries a response and a pop
      lat_min = 2; lat_max = 2;
      k = 0;
      while (!(mem_q.size() > 0 && mem_q[0].due == cyc) && k < 20) begin
         do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
         k++;
      end
      chk("t4_rv_found", 32'(k < 20), 32'd1);
      do_cycle(1'b0, 1'b1, 32'h0040_0181, 1'b1);
      chk("t4_empty", bus.ifq_empty, 1'b1);
      wait_head("t4_head", 32'h0040_0180);

      // Back-to-back redirects
      do_cycle(1'b0, 1'b1, 32'h0040_0200, 1'b0);
      do_cycle(1'b0, 1'b1, 32'h0040_0300, 1'b0);
      wait_head("t5_head", 32'h0040_0300);
      repeat (10) do_cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // Reset with entries queued and a request in flight
      lat_min = 1; lat_max = 1;
      do_cycle(1'b0, 1'b1, 32'h0040_0400, 1'b0);
      k = 0;
      while (m_q.size() < 3 && k < 20) begin
         do_cycle(1'b0, 1'b0, 32'h0, 1'b0);
         k++;
      end
      do_cycle(1'b1, 1'b0, 32'h0, 1'b0);
      chk("t6_empty", bus.ifq_empty, 1'b1);
      chk("t6_icode", bus.ifq_icode, 32'h0000_0013);
      chk("t6_addr", bus.imem_addr, 32'h0040_0000);

      // Randomized traffic across latencies
      lat_min = 1; lat_max = 1;
      repeat (400) rand_cycle(70, 3, 3);
      lat_min = 1; lat_max = 4;
      repeat (800) rand_cycle(60, 4, 5);
      lat_min = 2; lat_max = 6;
      repeat (600) rand_cycle(40, 10, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
